// File: rtl/i2c_apb_master_if.sv
// Command/response stream plus APB signals for the I2C register-block initiator.
// master: the APB initiator side; slave: the command source / APB target side.
// Pure wiring, no logic.
interface i2c_apb_master_if;
  // command stream
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // APB initiator
  logic        apb_sel;
  logic        apb_en;
  logic        apb_write;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  // status
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready, apb_ready, apb_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output apb_sel, apb_en, apb_write, apb_addr, apb_wdata, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready, apb_ready, apb_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  apb_sel, apb_en, apb_write, apb_addr, apb_wdata, busy
  );
endinterface

// File: rtl/i2c_apb_master.sv
// Turns a valid/ready command stream into single APB transfers, one response per command.
// Latency: handshake at edge N -> response after edge N+2 (+1 per wait state); unaligned after edge N.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; stalled slave bounded by TIMEOUT.
module i2c_apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rstn,
  i2c_apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Last ACCESS-cycle count value before the transfer is abandoned.
  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

  state_e      state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        apb_sel_q,   apb_sel_d;
  logic        apb_en_q,    apb_en_d;
  logic        apb_write_q, apb_write_d;
  logic [31:0] apb_addr_q,  apb_addr_d;
  logic [31:0] apb_wdata_q, apb_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        busy_q,      busy_d;

  // Next state, transfer bookkeeping and registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    apb_write_d = apb_write_q;
    apb_addr_d  = apb_addr_q;
    apb_wdata_d = apb_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_q is low for the first cycle after reset release, so gate on it.
        if (bus.cmd_valid && cmd_ready_q) begin
          apb_write_d = bus.cmd_write;
          apb_addr_d  = bus.cmd_addr;
          apb_wdata_d = bus.cmd_wdata;
          if (bus.cmd_addr[1:0] != 2'b00) begin
            // Unaligned: answer with an error without touching the bus.
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // apb_ready is checked first so it wins over the terminal count.
        if (bus.apb_ready) begin
          rsp_rdata_d = apb_write_q ? 32'd0 : bus.apb_rdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == TERM_CNT) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    cmd_ready_d = (state_d == IDLE);
    apb_sel_d   = (state_d == SETUP) || (state_d == ACCESS);
    apb_en_d    = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset drops the bus immediately and loses any in-flight command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      apb_sel_q   <= 1'b0;
      apb_en_q    <= 1'b0;
      apb_write_q <= 1'b0;
      apb_addr_q  <= '0;
      apb_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      apb_sel_q   <= apb_sel_d;
      apb_en_q    <= apb_en_d;
      apb_write_q <= apb_write_d;
      apb_addr_q  <= apb_addr_d;
      apb_wdata_q <= apb_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.apb_sel   = apb_sel_q;
  assign bus.apb_en    = apb_en_q;
  assign bus.apb_write = apb_write_q;
  assign bus.apb_addr  = apb_addr_q;
  assign bus.apb_wdata = apb_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_apb_master.sv
// Testbench for i2c_apb_master: directed scenarios followed by randomized transfers,
// each checked against a transaction-level reference model of latency, bus activity and response.
module tb_i2c_apb_master;
  localparam int TO = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  i2c_apb_master_if bus();

  i2c_apb_master #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc_ctr = 0;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what one command should produce, from the transfer rules alone.
  // waits = ACCESS cycles the slave keeps apb_ready low before raising it.
  function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                input logic [31:0] rd, output int acc, output logic err,
                                output logic [31:0] rdata, output int lat);
    if (addr % 4 != 0) begin
      acc = 0; err = 1'b1; rdata = 32'd0; lat = 1;
    end else if (waits >= TO) begin
      acc = TO; err = 1'b1; rdata = 32'd0; lat = 2 + TO;
    end else begin
      acc = waits + 1; err = 1'b0; rdata = wr ? 32'd0 : rd; lat = 2 + acc;
    end
  endfunction

  // Issue one command at the current negedge, play the slave, check the response.
  // Returns at a negedge with the response consumed; hs is the handshake cycle stamp.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int waits, input logic [31:0] rd, input int rdly,
                     output int unsigned hs);
    int acc, lat, cyc, sel_n, en_n, exp_sel;
    logic exp_err;
    logic [31:0] exp_rd;
    bit done, bad_hold, bad_ctl;
    model(wr, addr, waits, rd, acc, exp_err, exp_rd, lat);
    exp_sel = (addr % 4 != 0) ? 0 : acc + 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    cyc = 0; sel_n = 0; en_n = 0; done = 0; bad_hold = 0; bad_ctl = 0; hs = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        hs = cyc_ctr;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
      end
      if (bus.rsp_valid) begin
        done = 1;
      end else begin
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) bad_ctl = 1;
        if (bus.apb_sel) begin
          sel_n++;
          if (bus.apb_addr !== addr || bus.apb_write !== wr || bus.apb_wdata !== wd) bad_hold = 1;
        end
        if (bus.apb_en) begin
          bus.apb_ready = (en_n == waits);
          bus.apb_rdata = (en_n == waits) ? rd : $urandom;
          en_n++;
        end else begin
          bus.apb_ready = 1'($urandom);
          bus.apb_rdata = $urandom;
        end
      end
    end
    bus.apb_ready = 1'($urandom);
    chk("rsp_latency", 32'(cyc), 32'(lat));
    chk("sel_cycles", 32'(sel_n), 32'(exp_sel));
    chk("en_cycles", 32'(en_n), 32'(acc));
    chk("apb_hold_stable", 32'(bad_hold), 32'd0);
    chk("busy_and_cmd_ready_in_flight", 32'(bad_ctl), 32'd0);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("sel_in_resp", 32'({bus.apb_sel, bus.apb_en}), 32'd0);
    chk("apb_addr_kept", bus.apb_addr, addr);
    chk("apb_wdata_kept", bus.apb_wdata, wd);
    chk("apb_write_kept", 32'(bus.apb_write), 32'(wr));
    // Hold off the response; a pending command must not be taken meanwhile.
    bad_hold = 0;
    for (int i = 0; i < rdly; i++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp_err || bus.rsp_rdata !== exp_rd ||
          bus.cmd_ready !== 1'b0 || bus.apb_sel !== 1'b0 || bus.apb_addr !== addr)
        bad_hold = 1;
    end
    if (rdly > 0) chk("rsp_backpressure_hold", 32'(bad_hold), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done_idle", 32'({bus.rsp_valid, bus.cmd_ready, bus.busy}), 32'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs, hs_prev;
    logic [31:0] a, r, w;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.rsp_ready = 0; bus.apb_ready = 0; bus.apb_rdata = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("reset_apb_ctl", 32'({bus.apb_sel, bus.apb_en, bus.apb_write}), 32'd0);
    chk("reset_apb_addr", bus.apb_addr, 32'd0);
    chk("reset_apb_wdata", bus.apb_wdata, 32'd0);
    chk("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.busy}), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    rstn = 1'b1;
    #1 chk("cmd_ready_before_first_clock", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // Zero-wait write, 2-wait read, timeout, unaligned
    txn(1'b1, 32'h100, 32'h41, 0, 32'h0, 0, hs);
    txn(1'b0, 32'h128, 32'h0, 2, 32'h23a, 0, hs);
    txn(1'b0, 32'h200, 32'h0, 255, 32'hdead, 0, hs);
    txn(1'b1, 32'h102, 32'h55, 0, 32'h0, 0, hs);
    // Tie-break: ready in the TIMEOUT-th ACCESS cycle
    txn(1'b0, 32'h300, 32'h0, TO - 1, 32'h1234_5678, 0, hs);
    // Response backpressure
    txn(1'b0, 32'h40, 32'h0, 1, 32'hcafe_f00d, 5, hs);

    // Throughput: 4 zero-wait commands back to back
    txn(1'b1, 32'h10, 32'h1, 0, 32'h0, 0, hs_prev);
    for (int i = 1; i < 4; i++) begin
      txn(1'b0, 32'h10 + 32'(i * 4), 32'h0, 0, 32'(i * 17), 0, hs);
      chk("b2b_period", hs - hs_prev, 32'd4);
      hs_prev = hs;
    end

    // Reset during ACCESS: bus drops at once, no response, next command works
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h500; bus.cmd_wdata = 0;
    bus.apb_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_access", 32'({bus.apb_sel, bus.apb_en}), 32'b11);
    #2 rstn = 1'b0;
    #1;
    chk("midreset_apb_ctl", 32'({bus.apb_sel, bus.apb_en}), 32'd0);
    chk("midreset_rsp_busy", 32'({bus.rsp_valid, bus.busy, bus.cmd_ready}), 32'd0);
    chk("midreset_apb_addr", bus.apb_addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("postreset_no_rsp", 32'({bus.rsp_valid, bus.cmd_ready, bus.apb_sel}), 32'b010);
    txn(1'b0, 32'h504, 32'h0, 1, 32'h0bad_cafe, 0, hs);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      w = $urandom;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      txn(1'($urandom), a, w, $urandom_range(0, 20), r, $urandom_range(0, 3), hs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
